fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port: imem_req_addr  output  32  fetch address, equal to the pc register.
REQ-006 SHALL have port: imem_req_ready  input  1  instruction memory accepts the request.
REQ-007 SHALL have port: imem_rsp_valid  input  1  instruction word returned.
REQ-008 SHALL have port: imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port: redirect_valid  input  1  branch/jal taken from the execute stage.
REQ-010 SHALL have port: redirect_pc  input  32  target address, pc plus sign-extended immediate.
REQ-011 SHALL have port: instr_valid  output  1  FIFO head valid toward decode/extend.
REQ-012 SHALL have port: instr  output  32  FIFO head instruction word.
REQ-013 SHALL have port: instr_pc  output  32  FIFO head address.
REQ-014 SHALL have port: instr_ready  input  1  decode consumes the head.
REQ-015 SHALL have port: misalign_fault  output  1  rejected misaligned redirect; tied 0 without FETCH_ALIGN_CHECK_EN.

Function
REQ-016 SHALL hold a 2-entry FIFO of {pc, word}; instr_valid = count != 0; pop on instr_valid && instr_ready.
REQ-017 SHALL implement states S_REQ, S_WAIT and S_DROP, with at most one outstanding request.
REQ-018 SHALL drive imem_req_valid = (state == S_REQ) && (count < 2), with count taken before that cycle's pop.
REQ-019 SHALL, in S_REQ on valid && ready: latch the request pc, set pc <= pc + 4 (mod 2^32, wraps to 0) and go to S_WAIT.
REQ-020 SHALL, in S_WAIT on imem_rsp_valid: push {latched pc, imem_rsp_data} and go to S_REQ; the word is visible on instr one cycle after the response.
REQ-021 SHALL allow a push and a pop in the same cycle, leaving count unchanged.
REQ-022 SHALL ignore imem_rsp_valid while in S_REQ.
REQ-023 SHALL, on an accepted redirect: flush the FIFO and set pc <= redirect_pc; the redirect overrides pop, push and the pc + 4 increment in that cycle.
REQ-024 SHALL handle the redirect next state as follows:
- S_WAIT without a response: go to S_DROP.
- S_WAIT with a response in the same cycle: discard it and go to S_REQ.
- S_REQ coinciding with a request handshake: go to S_DROP.
- Otherwise: S_REQ.
REQ-025 SHALL, in S_DROP, discard the next response and go to S_REQ; a redirect in S_DROP updates pc and stays in S_DROP.
REQ-026 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready is low, unless a redirect occurs.

Reset
REQ-027 SHALL, while rst_n is low, immediately set: pc = RESET_PC, state = S_REQ, FIFO empty, instr_valid = 0, instr = 0, instr_pc = 0, misalign_fault = 0.
REQ-028 SHALL, on reset mid-request, abandon the outstanding request and not push its response after reset release.

Configuration
REQ-029 SHALL, with FETCH_ALIGN_CHECK_EN defined, treat a redirect with redirect_pc[1:0] != 0 as follows:
- Ignore it: no flush, pc and state unchanged.
- Pulse misalign_fault high for exactly the following cycle.
REQ-030 SHALL, without FETCH_ALIGN_CHECK_EN, use redirect_pc with bits [1:0] forced to 0 and hold misalign_fault at 0.

Verification
REQ-031 SHALL cover: reset release with RESET_PC = 0x100, ready = 1, 1-cycle response, instr_ready = 1 -> instr_pc sequence 0x100, 0x104, 0x108.
REQ-032 SHALL cover: instr_ready = 0 -> exactly 2 words buffered; imem_req_valid low with count = 2; resumes one cycle after the first pop.
REQ-033 SHALL cover: redirect to 0x200 while in S_WAIT; the stale response arrives 3 cycles later -> stale word discarded, next instr_pc = 0x200.
REQ-034 SHALL cover: redirect to 0x40 in the same cycle as a request handshake -> S_DROP; the next response is dropped; the first delivered word has instr_pc = 0x40.
REQ-035 SHALL cover: with the macro, redirect_pc = 0x202 -> misalign_fault pulses 1 cycle, the fetch stream continues unchanged; without the macro -> fetch restarts at 0x200.
REQ-036 SHALL cover: rst_n low while in S_WAIT with FIFO count 2 -> instr_valid = 0 immediately; after release, the first request address = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry {pc, word} FIFO toward decode,
// redirect flush with stale-response drop. Optional FETCH_ALIGN_CHECK_EN rejects misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_fault
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t       state;
  logic [31:0]  pc, req_pc;
  fetch_entry_t fifo [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic         req_hs, push, pop, redir_take;
  logic [31:0]  redir_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic redir_bad;
  assign redir_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_take = redirect_valid && !redir_bad;
  assign redir_tgt  = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_fault <= 1'b0;
    else        misalign_fault <= redir_bad;
  end
`else
  assign redir_take     = redirect_valid;
  assign redir_tgt      = redirect_pc & ~32'h3;
  assign misalign_fault = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ) && (count != 2'd2);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid;
  assign instr_valid    = (count != 2'd0);
  assign pop            = instr_valid && instr_ready;
  assign instr          = fifo[rd_ptr].word;
  assign instr_pc       = fifo[rd_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      req_pc  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else if (redir_take) begin
      pc     <= redir_tgt;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      case (state)
        S_REQ:   state <= req_hs ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        // a response landing with the redirect is the one being dropped, so nothing is left in flight
        default: state <= imem_rsp_valid ? S_REQ : S_DROP;
      endcase
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {req_pc, imem_rsp_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      case (state)
        S_REQ: if (req_hs) begin
          req_pc <= pc;
          pc     <= pc + 32'd4;
          state  <= S_WAIT;
        end
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        default: if (imem_rsp_valid) state <= S_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable imem responder, expected-pc scoreboard
// checked on every decode pop, plus immediate assertions at each directed step.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  int          n_err = 0;
  int          n_chk = 0;
  int          hs_cnt = 0;
  int          lat = 1;
  logic [31:0] sb [$];

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5EED;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: handshake decided mid-cycle, response driven just after a posedge for `lat` cycles later.
  always begin : responder
    logic        hs_s, pend;
    logic [31:0] a_s, paddr;
    int          cnt;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk); #1;
      hs_s = rst_n && imem_req_valid && imem_req_ready;
      a_s  = imem_req_addr;
      if (hs_s) hs_cnt++;
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (hs_s) begin pend = 1'b1; cnt = lat; paddr = a_s; end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word_of(paddr);
          pend = 1'b0;
        end else cnt--;
      end
    end
  end

  // Every pop toward decode must match the oldest expected pc and its word.
  always begin : monitor
    logic [31:0] e;
    @(negedge clk); #1;
    if (rst_n && instr_valid && instr_ready) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_pop: instr_pc %h with empty scoreboard", instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_word", instr, word_of(e));
      end
    end
  end

  task automatic run_hs(input int n);
    int tgt, k;
    tgt = hs_cnt + n;
    k = 0;
    imem_req_ready = 1'b1;
    while (hs_cnt < tgt && k < 100) begin @(negedge clk); k++; end
    imem_req_ready = 1'b0;
    chk("hs_count", 32'(hs_cnt), 32'(tgt));
  endtask

  task automatic drain();
    int k;
    k = 0;
    instr_ready = 1'b1;
    while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc, a_pc;
    int base, k;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_misalign", 32'(misalign_fault), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h100);

    // Streaming from RESET_PC, 1-cycle responses, decode always ready.
    sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
    lat = 1; instr_ready = 1'b1; rst_n = 1'b1;
    run_hs(3);
    drain();

    // Decode stalled: two words buffer, requests stop, resume one cycle after a pop.
    base = hs_cnt; instr_ready = 1'b0; lat = 1;
    sb.push_back(32'h10c); sb.push_back(32'h110); sb.push_back(32'h114);
    imem_req_ready = 1'b1; k = 0;
    while (hs_cnt < base + 2 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("full_hs", 32'(hs_cnt), 32'(base + 2));
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_req_low", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", instr_pc, 32'h10c);
    chk("full_req_addr", imem_req_addr, 32'h114);
    instr_ready = 1'b1;
    chk("full_req_low_at_pop", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("resume_req", 32'(imem_req_valid), 32'd1);
    chk("resume_head_pc", instr_pc, 32'h110);
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("resume_hs", 32'(hs_cnt), 32'(base + 3));
    drain();

    // Redirect while waiting; stale response three cycles after the redirect.
    lat = 4;
    run_hs(1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    sb.push_back(32'h200); sb.push_back(32'h204);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop_req_low", 32'(imem_req_valid), 32'd0);
    chk("drop_pc", imem_req_addr, 32'h200);
    repeat (5) @(negedge clk);
    chk("stale_discarded", 32'(instr_valid), 32'd0);
    chk("after_drop_req", 32'(imem_req_valid), 32'd1);
    lat = 1;
    run_hs(2);
    drain();

    // Redirect coinciding with a handshake: the in-flight response is dropped.
    base = hs_cnt; lat = 2; instr_ready = 1'b0;
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    sb.push_back(32'h40);
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("hs_redir_count", 32'(hs_cnt), 32'(base + 1));
    chk("hs_redir_req_low", 32'(imem_req_valid), 32'd0);
    chk("hs_redir_pc", imem_req_addr, 32'h40);
    repeat (4) @(negedge clk);
    chk("hs_redir_dropped", 32'(instr_valid), 32'd0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stall_addr_a", imem_req_addr, 32'h40);
    @(negedge clk);
    chk("stall_addr_b", imem_req_addr, 32'h40);
    lat = 1;
    run_hs(1);
    drain();

    // Misaligned redirect: rejected with a one-cycle fault, or aligned down without the check.
    exp_pc = ALIGN_CHK ? 32'h44 : 32'h200;
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("misalign_pulse", 32'(misalign_fault), 32'(ALIGN_CHK));
    chk("misalign_pc", imem_req_addr, exp_pc);
    chk("misalign_req", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    chk("misalign_clear", 32'(misalign_fault), 32'd0);
    sb.push_back(exp_pc);
    run_hs(1);
    drain();

    // Reset with a buffered word and a request outstanding.
    a_pc = exp_pc + 32'd4;
    instr_ready = 1'b0; lat = 1;
    run_hs(1);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("pre_rst_pc", instr_pc, a_pc);
    lat = 5;
    run_hs(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    chk("mid_rst_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_no_push", 32'(instr_valid), 32'd0);
    chk("post_rst_req", 32'(imem_req_valid), 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h100);
    sb.push_back(32'h100);
    lat = 1;
    run_hs(1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
